// File: rtl/zint_mc.sv
// -----------------------------------------------------------------------------
// zint_mc - Z80 IM2 interrupt controller with NSRC prioritised sources.
//
// Collects one-clk request strobes from the frame/line/DMA/event generators,
// keeps a pending flag per source, drives the CPU ~INT line and, on each
// rising edge of the CPU acknowledge, latches the winning source so the IM2
// vector can be presented on the data bus.
//
// Parameters
//   NSRC       number of sources (1..16), index 0 is the highest priority
//   PULSE_LEN  zclk_en ticks a pulse-mode request survives without an ack
//   PULSE_MASK bit i=1: source i is pulse-mode (self-expiring)
//   VDOS_DROP  bit i=1: source i is cleared and blocked while vdos=1
//   VECT_BASE  vector of source 0; source i uses VECT_BASE - 2*i (mod 256)
//
// Ports
//   clk        in   system clock
//   res        in   synchronous active-high reset
//   zclk_en    in   one-clk strobe per Z80 clock, advances the pulse timers
//   int_start  in   [NSRC] request strobes, bit i = source i
//   intmask    in   [NSRC] per-source enable, 0 clears and blocks the source
//   vdos       in   VDOS active, hides all requests from the CPU
//   intack     in   CPU acknowledge level, rising edge is the ack event
//   int_pend   out  [NSRC] registered pending flags
//   im2vect    out  [8] IM2 vector of the last acknowledged source
//   int_n      out  ~INT to the CPU, active-low
// -----------------------------------------------------------------------------
module zint_mc #(
   parameter int          NSRC       = 8,
   parameter int          PULSE_LEN  = 32,
   parameter logic [15:0] PULSE_MASK = 16'h0001,
   parameter logic [15:0] VDOS_DROP  = 16'h0003,
   parameter logic [7:0]  VECT_BASE  = 8'hFF
) (
   input  logic            clk,
   input  logic            res,
   input  logic            zclk_en,
   input  logic [NSRC-1:0] int_start,
   input  logic [NSRC-1:0] intmask,
   input  logic            vdos,
   input  logic            intack,
   output logic [NSRC-1:0] int_pend,
   output logic [7:0]      im2vect,
   output logic            int_n
);

   localparam int            TW    = $clog2(PULSE_LEN + 1);
   localparam logic [TW-1:0] TMAX  = TW'(PULSE_LEN);
   localparam logic [TW-1:0] TONE  = TW'(1);
   // One code past the largest source index marks "no source acknowledged".
   localparam logic [4:0]    DUMMY = 5'd16;

   logic [NSRC-1:0] pend_q;
   logic [NSRC-1:0] pend_d;
   logic [NSRC-1:0] visible_s;
   logic [TW-1:0]   timer_q [NSRC];
   logic [TW-1:0]   timer_d [NSRC];
   logic            intack_q;
   logic            ack_s;
   logic            any_vis_s;
   logic [3:0]      win_s;
   logic [4:0]      sel_q;
   logic [4:0]      sel_d;

   // IM2 vector for a latched selection; the dummy selection maps to the base.
   function automatic logic [7:0] vect_of(input logic [4:0] sel);
      logic [7:0] v;
      if (sel == DUMMY) begin
         v = VECT_BASE;
      end else begin
         v = VECT_BASE - {3'b000, sel[3:0], 1'b0};
      end
      return v;
   endfunction

   // Requests visible to the CPU, the ack edge and the priority winner.
   always_comb begin
      visible_s = vdos ? {NSRC{1'b0}} : pend_q;
      any_vis_s = |visible_s;
      ack_s     = intack & ~intack_q;
      win_s     = 4'd0;
      // Scan from the lowest priority upward so the lowest set index wins.
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (visible_s[i]) begin
            win_s = 4'(i);
         end else begin
            win_s = win_s;
         end
      end
   end

   // Next pending flags and pulse timers, rules listed in priority order.
   always_comb begin
      pend_d = pend_q;
      for (int i = 0; i < NSRC; i++) begin
         timer_d[i] = timer_q[i];
         if (res || !intmask[i] || (vdos && VDOS_DROP[i])) begin
            pend_d[i] = 1'b0;
         end else if (int_start[i]) begin
            // A fresh strobe beats a same-cycle ack or expiry.
            pend_d[i] = 1'b1;
         end else if (ack_s && any_vis_s && (win_s == 4'(i))) begin
            pend_d[i] = 1'b0;
         end else if (PULSE_MASK[i] && (timer_q[i] == TMAX)) begin
            pend_d[i] = 1'b0;
         end else begin
            pend_d[i] = pend_q[i];
         end

         if (res || !PULSE_MASK[i]) begin
            timer_d[i] = TMAX;
         end else if (int_start[i]) begin
            // Restart the window, also when the source is already pending.
            timer_d[i] = {TW{1'b0}};
         end else if (zclk_en && (timer_q[i] < TMAX)) begin
            timer_d[i] = timer_q[i] + TONE;
         end else begin
            timer_d[i] = timer_q[i];
         end
      end
   end

   // Latched selection: winner on an ack, dummy on a spurious ack.
   always_comb begin
      sel_d = sel_q;
      if (res) begin
         sel_d = DUMMY;
      end else if (ack_s) begin
         sel_d = any_vis_s ? {1'b0, win_s} : DUMMY;
      end else begin
         sel_d = sel_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (res) begin
         pend_q   <= {NSRC{1'b0}};
         intack_q <= 1'b0;
         sel_q    <= DUMMY;
         for (int i = 0; i < NSRC; i++) begin
            timer_q[i] <= TMAX;
         end
      end else begin
         pend_q   <= pend_d;
         intack_q <= intack;
         sel_q    <= sel_d;
         for (int i = 0; i < NSRC; i++) begin
            timer_q[i] <= timer_d[i];
         end
      end
   end

   // Outputs derive from registers; vdos only masks ~INT, so held sources
   // reappear on the CPU line the moment vdos falls.
   always_comb begin
      int_pend = pend_q;
      int_n    = ~any_vis_s;
      im2vect  = vect_of(sel_q);
   end

endmodule
